// File: rtl/fir_err_monitor_if.sv
// Sample/result bundle between a FIR pair and the error monitor.
// With ERR_SQ_EN defined the bundle also carries sum_sq_err.
interface fir_err_monitor_if #(
  parameter int W        = 16,
  parameter int WIN_LOG2 = 8,
  parameter int ACC_W    = W + WIN_LOG2
);
  logic                  start;
  logic                  in_valid;
  logic [W-1:0]          exact_in;
  logic [W-1:0]          approx_in;
  logic                  busy;
  logic                  done;
  logic [ACC_W-1:0]      sum_abs_err;
  logic [W-1:0]          max_abs_err;
  logic [WIN_LOG2:0]     err_cnt;
`ifdef ERR_SQ_EN
  logic [2*W+WIN_LOG2-1:0] sum_sq_err;
`endif

  modport master (
    output start, in_valid, exact_in, approx_in,
`ifdef ERR_SQ_EN
    input  sum_sq_err,
`endif
    input  busy, done, sum_abs_err, max_abs_err, err_cnt
  );

  modport slave (
    input  start, in_valid, exact_in, approx_in,
`ifdef ERR_SQ_EN
    output sum_sq_err,
`endif
    output busy, done, sum_abs_err, max_abs_err, err_cnt
  );
endinterface

// File: rtl/fir_err_monitor.sv
// Error-metric accumulator comparing exact vs approximate FIR output streams.
// Optional squared-error sum enabled by macro ERR_SQ_EN.
module fir_err_monitor #(
  parameter int W        = 16,
  parameter int WIN_LOG2 = 8,
  parameter int WARMUP   = 4,
  parameter int ACC_W    = W + WIN_LOG2
) (
  input  logic              clk,
  input  logic              rst,
  fir_err_monitor_if.slave  bus
);
  localparam int WC_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int SQ_W = 2*W + WIN_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_WARM, S_ACCUM, S_DONE} state_t;

  state_t               state;
  logic [WC_W-1:0]      wcnt;
  logic [WIN_LOG2-1:0]  scnt;
  logic                 busy_r, done_r;
  logic [ACC_W-1:0]     sum_r;
  logic [W-1:0]         max_r;
  logic [WIN_LOG2:0]    cnt_r;
  logic [W-1:0]         diff;
  logic                 warm_last;

  // Larger minus smaller keeps the magnitude on W bits without a sign bit.
  always_comb begin
    diff = (bus.exact_in >= bus.approx_in) ? (bus.exact_in - bus.approx_in)
                                           : (bus.approx_in - bus.exact_in);
  end

  assign warm_last = (int'(wcnt) == WARMUP - 1);

`ifdef ERR_SQ_EN
  logic [SQ_W-1:0]  sq_r;
  logic [2*W-1:0]   sq;
  always_comb sq = {{W{1'b0}}, diff} * {{W{1'b0}}, diff};
  assign bus.sum_sq_err = sq_r;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      wcnt   <= '0;
      scnt   <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      sum_r  <= '0;
      max_r  <= '0;
      cnt_r  <= '0;
`ifdef ERR_SQ_EN
      sq_r   <= '0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            wcnt   <= '0;
            scnt   <= '0;
            sum_r  <= '0;
            max_r  <= '0;
            cnt_r  <= '0;
`ifdef ERR_SQ_EN
            sq_r   <= '0;
`endif
            busy_r <= 1'b1;
            if (WARMUP == 0) state <= S_ACCUM;
            else             state <= S_WARM;
          end
        end
        S_WARM: begin
          if (bus.in_valid) begin
            wcnt <= wcnt + 1'b1;
            if (warm_last) state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (bus.in_valid) begin
            sum_r <= sum_r + ACC_W'(diff);
            if (diff > max_r) max_r <= diff;
            cnt_r <= cnt_r + (WIN_LOG2+1)'(diff != '0);
`ifdef ERR_SQ_EN
            sq_r  <= sq_r + SQ_W'(sq);
`endif
            scnt  <= scnt + 1'b1;
            // scnt all-ones marks the last sample of the window
            if (&scnt) begin
              state  <= S_DONE;
              done_r <= 1'b1;
              busy_r <= 1'b0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.sum_abs_err = sum_r;
  assign bus.max_abs_err = max_r;
  assign bus.err_cnt     = cnt_r;
endmodule

// File: tb/tb_fir_err_monitor.sv
// Directed bench for fir_err_monitor, WIN_LOG2=2, WARMUP=4.
module tb_fir_err_monitor;
  localparam int W = 16, WL = 2, WU = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fir_err_monitor_if #(.W(W), .WIN_LOG2(WL)) bus ();

  fir_err_monitor #(.W(W), .WIN_LOG2(WL), .WARMUP(WU)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Inputs change on negedge; one call spans exactly one posedge.
  task automatic smp(input int e, input int a);
    bus.in_valid  = 1'b1;
    bus.exact_in  = 16'(e);
    bus.approx_in = 16'(a);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic start_pulse();
    bus.in_valid = 1'b0;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  task automatic warm4();
    for (int i = 0; i < WU; i++) smp(100, 0);
  endtask

  task automatic res(input string tag, input int s, input int m, input int c);
    chk({tag, ".sum"}, 64'(bus.sum_abs_err), 64'(s));
    chk({tag, ".max"}, 64'(bus.max_abs_err), 64'(m));
    chk({tag, ".cnt"}, 64'(bus.err_cnt), 64'(c));
  endtask

  initial begin
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.exact_in = '0; bus.approx_in = '0;
    repeat (3) @(negedge clk);
    chk("rst.busy", 64'(bus.busy), 0);
    chk("rst.done", 64'(bus.done), 0);
    res("rst", 0, 0, 0);
    rst = 1'b0;
    idle(1);

    // main window
    start_pulse();
    chk("a.busy", 64'(bus.busy), 1);
    warm4();
    chk("a.warm_sum", 64'(bus.sum_abs_err), 0);
    smp(10, 10); smp(20, 18);
    res("a.part", 2, 2, 1);
    smp(5, 9);
    chk("a.early_done", 64'(bus.done), 0);
    smp(65535, 0);
    chk("a.done", 64'(bus.done), 1);
    chk("a.busy_end", 64'(bus.busy), 0);
    res("a", 65541, 65535, 3);
`ifdef ERR_SQ_EN
    chk("a.sq", 64'(bus.sum_sq_err), 64'd4294836245);
`endif
    idle(1);
    chk("a.done_once", 64'(bus.done), 0);
    smp(1, 0); idle(1);
    chk("a.hold_sum", 64'(bus.sum_abs_err), 65541);
    chk("a.hold_busy", 64'(bus.busy), 0);

    // stalled window from DONE
    start_pulse();
    res("b.clr", 0, 0, 0);
    for (int i = 0; i < WU; i++) begin smp(100, 0); idle(3); end
    smp(10, 10); idle(3); smp(20, 18); idle(3); smp(5, 9); idle(3);
    chk("b.early_done", 64'(bus.done), 0);
    chk("b.busy", 64'(bus.busy), 1);
    smp(65535, 0);
    chk("b.done", 64'(bus.done), 1);
    res("b", 65541, 65535, 3);
    idle(1);
    chk("b.done_once", 64'(bus.done), 0);

    // start during ACCUM is ignored
    start_pulse(); warm4();
    smp(10, 10); smp(20, 18);
    start_pulse();
    chk("c.no_clr", 64'(bus.sum_abs_err), 2);
    chk("c.busy", 64'(bus.busy), 1);
    smp(5, 9);
    chk("c.early_done", 64'(bus.done), 0);
    smp(65535, 0);
    chk("c.done", 64'(bus.done), 1);
    res("c", 65541, 65535, 3);

    // start held through first DONE cycle
    start_pulse(); warm4();
    smp(10, 10); smp(20, 18); smp(5, 9);
    bus.start = 1'b1;
    smp(65535, 0);
    chk("d.done", 64'(bus.done), 1);
    chk("d.sum", 64'(bus.sum_abs_err), 65541);
    idle(1);
    chk("d.done_once", 64'(bus.done), 0);
    chk("d.busy", 64'(bus.busy), 1);
    res("d.clr", 0, 0, 0);
    bus.start = 1'b0;
    warm4();
    smp(7, 7); smp(0, 0); smp(65535, 65535); smp(300, 300);
    chk("d.done2", 64'(bus.done), 1);
    res("d.eq", 0, 0, 0);
`ifdef ERR_SQ_EN
    chk("d.sq", 64'(bus.sum_sq_err), 0);
`endif

    // reset mid-ACCUM
    idle(1);
    start_pulse(); warm4();
    smp(20, 18); smp(5, 9);
    res("e.part", 6, 4, 2);
    bus.in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("e.busy", 64'(bus.busy), 0);
    chk("e.done", 64'(bus.done), 0);
    res("e.rst", 0, 0, 0);
    smp(50, 0); idle(1);
    chk("e.idle_ign", 64'(bus.sum_abs_err), 0);
    start_pulse(); warm4();
    smp(10, 10); smp(20, 18); smp(5, 9); smp(65535, 0);
    chk("e.done2", 64'(bus.done), 1);
    res("e", 65541, 65535, 3);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
